axi_wr_arbiter: RTL and testbench

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

---
 rtl/axi_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/axi_wr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and AXI field widths for the two-master AXI write arbiter.
package axi_arb_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int LEN_W  = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AW   = 2'd1,
    ARB_W    = 2'd2,
    ARB_B    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way requester pick: a single requester always wins; on contention the
// priority pointer decides (round-robin) or master 0 wins (fixed priority).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       rr_en,
  output logic       gnt_idx,
  output logic       gnt_vld
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    gnt_idx = 1'b0;
    gnt_vld = |req;
    case (req)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = rr_en ? ptr : 1'b0;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write arbiter: owns one AW/W/B transaction at a time and
// routes the granted master to the single slave port combinationally.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ID_W-1:0]   m0_awid,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic [LEN_W-1:0]  m0_awlen,
  input  logic [2:0]        m0_awsize,
  input  logic [1:0]        m0_awburst,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [ID_W-1:0]   m0_wid,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  input  logic              m0_wlast,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  output logic [ID_W-1:0]   m0_bid,
  output logic [1:0]        m0_bresp,
  output logic              m0_bvalid,
  input  logic              m0_bready,

  input  logic [ID_W-1:0]   m1_awid,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [LEN_W-1:0]  m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ID_W-1:0]   m1_wid,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic              m1_wlast,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic [ID_W-1:0]   m1_bid,
  output logic [1:0]        m1_bresp,
  output logic              m1_bvalid,
  input  logic              m1_bready,

  output logic [ID_W-1:0]   s_awid,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [LEN_W-1:0]  s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ID_W-1:0]   s_wid,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  output logic              s_wlast,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic [ID_W-1:0]   s_bid,
  input  logic [1:0]        s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready,

  output logic              grant,
  output logic              busy,
  output logic              err_wlast
);

  arb_state_t       state;
  logic             grant_q;
  logic             ptr_q;
  logic             err_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;

  logic             pick_idx;
  logic             pick_vld;
  logic             sel_awvalid;
  logic             sel_wvalid;
  logic             sel_bready;
  logic [LEN_W-1:0] sel_awlen;
  logic             route_aw;
  logic             route_w;
  logic             route_b;
  logic             aw_hs;
  logic             w_hs;
  logic             b_hs;
  logic             cnt_at_len;

  rr_arb2 u_pick (
    .req     ({m1_awvalid, m0_awvalid}),
    .ptr     (ptr_q),
    .rr_en   (RR_EN),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  assign sel_awvalid = grant_q ? m1_awvalid : m0_awvalid;
  assign sel_awlen   = grant_q ? m1_awlen   : m0_awlen;
  assign sel_wvalid  = grant_q ? m1_wvalid  : m0_wvalid;
  assign sel_bready  = grant_q ? m1_bready  : m0_bready;

  // Handshake qualifiers are forced low while reset is held, so the slave and
  // both masters see a quiet bus before the first clock edge has landed.
  assign route_aw = !reset && (state == ARB_AW);
  assign route_w  = !reset && (state == ARB_W);
  assign route_b  = !reset && (state == ARB_B);

  assign aw_hs      = route_aw && sel_awvalid && s_awready;
  assign w_hs       = route_w  && sel_wvalid  && s_wready;
  assign b_hs       = route_b  && s_bvalid    && sel_bready;
  assign cnt_at_len = (beat_cnt == len_q);

  always_ff @(posedge clk) begin
    // NOTE: all state updates are non-blocking so every register samples the
    // pre-edge values of its peers, independent of statement order.
    if (reset) begin
      state    <= ARB_IDLE;
      grant_q  <= 1'b0;
      ptr_q    <= 1'b0;
      err_q    <= 1'b0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_idx;
            state   <= ARB_AW;
          end
        end
        ARB_AW: begin
          if (aw_hs) begin
            len_q    <= sel_awlen;
            beat_cnt <= '0;
            state    <= ARB_W;
          end
        end
        ARB_W: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (s_wlast || cnt_at_len) begin
              // Either terminator alone means wlast and the count disagree.
              err_q <= s_wlast ^ cnt_at_len;
              state <= ARB_B;
            end
          end
        end
        ARB_B: begin
          if (b_hs) begin
            ptr_q <= ~grant_q;
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign s_awid    = grant_q ? m1_awid    : m0_awid;
  assign s_awaddr  = grant_q ? m1_awaddr  : m0_awaddr;
  assign s_awlen   = sel_awlen;
  assign s_awsize  = grant_q ? m1_awsize  : m0_awsize;
  assign s_awburst = grant_q ? m1_awburst : m0_awburst;
  assign s_awvalid = route_aw && sel_awvalid;
  assign m0_awready = route_aw && !grant_q && s_awready;
  assign m1_awready = route_aw &&  grant_q && s_awready;

  assign s_wid    = grant_q ? m1_wid   : m0_wid;
  assign s_wdata  = grant_q ? m1_wdata : m0_wdata;
  assign s_wstrb  = grant_q ? m1_wstrb : m0_wstrb;
  assign s_wlast  = grant_q ? m1_wlast : m0_wlast;
  assign s_wvalid = route_w && sel_wvalid;
  assign m0_wready = route_w && !grant_q && s_wready;
  assign m1_wready = route_w &&  grant_q && s_wready;

  assign m0_bid    = s_bid;
  assign m1_bid    = s_bid;
  assign m0_bresp  = s_bresp;
  assign m1_bresp  = s_bresp;
  assign m0_bvalid = route_b && !grant_q && s_bvalid;
  assign m1_bvalid = route_b &&  grant_q && s_bvalid;
  assign s_bready  = route_b && sel_bready;

  assign grant     = grant_q;
  assign busy      = !reset && (state != ARB_IDLE);
  assign err_wlast = err_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: round-robin instance for most scenarios,
// a fixed-priority instance sharing the same stimulus for the RR_EN=0 case.
module tb_axi_wr_arbiter;
  import axi_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]  m_awid    [2];
  logic [31:0] m_awaddr  [2];
  logic [3:0]  m_awlen   [2];
  logic [2:0]  m_awsize  [2];
  logic [1:0]  m_awburst [2];
  logic        m_awvalid [2];
  logic [3:0]  m_wid     [2];
  logic [31:0] m_wdata   [2];
  logic [3:0]  m_wstrb   [2];
  logic        m_wlast   [2];
  logic        m_wvalid  [2];
  logic        m_bready  [2];
  logic        s_awready, s_wready, s_bvalid;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;

  logic        m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid, m1_bvalid;
  logic [3:0]  m0_bid, m1_bid;
  logic [1:0]  m0_bresp, m1_bresp;
  logic [3:0]  s_awid, s_awlen, s_wid, s_wstrb;
  logic [31:0] s_awaddr, s_wdata;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_awvalid, s_wlast, s_wvalid, s_bready, grant, busy, err_wlast;

  logic        f_m0_awready, f_m1_awready, f_m0_wready, f_m1_wready, f_m0_bvalid, f_m1_bvalid;
  logic [3:0]  f_m0_bid, f_m1_bid;
  logic [1:0]  f_m0_bresp, f_m1_bresp;
  logic [3:0]  f_s_awid, f_s_awlen, f_s_wid, f_s_wstrb;
  logic [31:0] f_s_awaddr, f_s_wdata;
  logic [2:0]  f_s_awsize;
  logic [1:0]  f_s_awburst;
  logic        f_s_awvalid, f_s_wlast, f_s_wvalid, f_s_bready, f_grant, f_busy, f_err_wlast;

  axi_wr_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .m0_awid(m_awid[0]), .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awsize(m_awsize[0]),
    .m0_awburst(m_awburst[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(m0_awready),
    .m0_wid(m_wid[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wready(m0_wready),
    .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m_bready[0]),
    .m1_awid(m_awid[1]), .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awsize(m_awsize[1]),
    .m1_awburst(m_awburst[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(m1_awready),
    .m1_wid(m_wid[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wready(m1_wready),
    .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m_bready[1]),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant), .busy(busy), .err_wlast(err_wlast)
  );

  axi_wr_arbiter #(.RR_EN(1'b0)) dut_fixed (
    .clk(clk), .reset(reset),
    .m0_awid(m_awid[0]), .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awsize(m_awsize[0]),
    .m0_awburst(m_awburst[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(f_m0_awready),
    .m0_wid(m_wid[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wready(f_m0_wready),
    .m0_bid(f_m0_bid), .m0_bresp(f_m0_bresp), .m0_bvalid(f_m0_bvalid), .m0_bready(m_bready[0]),
    .m1_awid(m_awid[1]), .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awsize(m_awsize[1]),
    .m1_awburst(m_awburst[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(f_m1_awready),
    .m1_wid(m_wid[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wready(f_m1_wready),
    .m1_bid(f_m1_bid), .m1_bresp(f_m1_bresp), .m1_bvalid(f_m1_bvalid), .m1_bready(m_bready[1]),
    .s_awid(f_s_awid), .s_awaddr(f_s_awaddr), .s_awlen(f_s_awlen), .s_awsize(f_s_awsize),
    .s_awburst(f_s_awburst), .s_awvalid(f_s_awvalid), .s_awready(s_awready),
    .s_wid(f_s_wid), .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb), .s_wlast(f_s_wlast),
    .s_wvalid(f_s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(f_s_bready),
    .grant(f_grant), .busy(f_busy), .err_wlast(f_err_wlast)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic awready_of(input int m);
    return (m == 1) ? m1_awready : m0_awready;
  endfunction
  function automatic logic wready_of(input int m);
    return (m == 1) ? m1_wready : m0_wready;
  endfunction
  function automatic logic bvalid_of(input int m);
    return (m == 1) ? m1_bvalid : m0_bvalid;
  endfunction
  function automatic logic [3:0] bid_of(input int m);
    return (m == 1) ? m1_bid : m0_bid;
  endfunction
  function automatic logic [1:0] bresp_of(input int m);
    return (m == 1) ? m1_bresp : m0_bresp;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic all_idle();
    for (int m = 0; m < 2; m++) begin
      m_awid[m] = '0; m_awaddr[m] = '0; m_awlen[m] = '0; m_awsize[m] = 3'd2;
      m_awburst[m] = BURST_INCR; m_awvalid[m] = 1'b0;
      m_wid[m] = '0; m_wdata[m] = '0; m_wstrb[m] = '0; m_wlast[m] = 1'b0;
      m_wvalid[m] = 1'b0; m_bready[m] = 1'b0;
    end
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
  endtask

  // Reset held for three edges; bus outputs must stay quiet whatever the inputs do.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    sample();
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_s_awvalid", s_awvalid, 0);
    check("rst_s_wvalid", s_wvalid, 0);
    check("rst_s_bready", s_bready, 0);
    check("rst_m0_awready", m0_awready, 0);
    check("rst_m0_bvalid", m0_bvalid, 0);
    check("rst_err", err_wlast, 0);
    tick();
    reset = 1'b0;
    all_idle();
  endtask

  task automatic aw_phase(input int m, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, output int waited);
    int k;
    m_awid[m] = id; m_awaddr[m] = addr; m_awlen[m] = len;
    m_awsize[m] = 3'd2; m_awburst[m] = BURST_INCR; m_awvalid[m] = 1'b1;
    s_awready = 1'b1;
    sample();
    for (k = 0; k < 20 && !(busy && grant == 1'(m) && awready_of(m)); k++) begin
      tick();
      sample();
    end
    waited = k;
    check("aw_timeout", k < 20, 1);
    check("aw_grant", grant, m);
    check("aw_s_awvalid", s_awvalid, 1);
    check("aw_s_awid", s_awid, id);
    check("aw_s_awaddr", s_awaddr, addr);
    check("aw_s_awlen", s_awlen, len);
    check("aw_s_awburst", s_awburst, BURST_INCR);
    check("aw_other_awready", awready_of(1 - m), 0);
    tick();
    m_awvalid[m] = 1'b0;
    s_awready = 1'b0;
  endtask

  // Drives nbeats beats; wlast on beat last_beat (1-based, 0 = never);
  // slave stalls 3 cycles before beat index stall_at.
  task automatic w_phase(input int m, input int nbeats, input int last_beat, input int stall_at);
    int seen = 0;
    for (int i = 0; i < nbeats; i++) begin
      m_wid[m] = 4'(m + 8); m_wstrb[m] = 4'hF;
      m_wdata[m] = 32'hCAFE_0000 + 32'(m * 256 + i);
      m_wlast[m] = (i + 1 == last_beat);
      m_wvalid[m] = 1'b1;
      if (i == stall_at) begin
        s_wready = 1'b0;
        repeat (3) begin
          sample();
          check("w_stall_wready", wready_of(m), 0);
          check("w_stall_busy", busy, 1);
          if (s_wvalid && s_wready) seen++;
          tick();
        end
      end
      s_wready = 1'b1;
      sample();
      check("w_s_wvalid", s_wvalid, 1);
      check("w_wready", wready_of(m), 1);
      check("w_s_wdata", s_wdata, 32'hCAFE_0000 + 32'(m * 256 + i));
      check("w_s_wstrb", s_wstrb, 4'hF);
      check("w_other_awready", awready_of(1 - m), 0);
      if (s_wvalid && s_wready) seen++;
      tick();
    end
    m_wvalid[m] = 1'b0;
    m_wlast[m] = 1'b0;
    s_wready = 1'b0;
    check("w_beat_count", seen, nbeats);
  endtask

  task automatic b_phase(input int m, input logic [3:0] id, input logic [1:0] resp,
                         input int b_delay, input int bready_low, input logic exp_err);
    int c;
    for (c = 0; c < 40; c++) begin
      s_bvalid = (c >= b_delay);
      s_bid = id;
      s_bresp = resp;
      m_bready[m] = (c >= b_delay + bready_low);
      sample();
      if (c == 0) check("b_err_wlast", err_wlast, exp_err);
      check("b_busy", busy, 1);
      check("b_bvalid", bvalid_of(m), s_bvalid);
      check("b_other_bvalid", bvalid_of(1 - m), 0);
      if (s_bvalid && m_bready[m]) begin
        check("b_s_bready", s_bready, 1);
        check("b_bid", bid_of(m), id);
        check("b_bresp", bresp_of(m), resp);
        tick();
        break;
      end
      check("b_s_bready_wait", s_bready, m_bready[m]);
      tick();
    end
    check("b_timeout", c < 40, 1);
    s_bvalid = 1'b0;
    m_bready[m] = 1'b0;
    sample();
    check("b_idle_busy", busy, 0);
    check("b_err_cleared", err_wlast, 0);
    check("b_idle_bvalid", bvalid_of(m), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int waited;
    int cnt_g1, cnt_m1, cnt_b, cnt_busy, cnt_err;

    // Reset with live requests and ready/valid inputs asserted.
    all_idle();
    m_awvalid[0] = 1'b1; m_wvalid[0] = 1'b1; m_bready[0] = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
    do_reset();

    // Single master, 4-beat INCR burst.
    m_awvalid[0] = 1'b1;
    sample();
    check("idle_s_awvalid", s_awvalid, 0);
    check("idle_m0_awready", m0_awready, 0);
    check("idle_busy", busy, 0);
    aw_phase(0, 4'd3, 32'h10, 4'd3, waited);
    check("single_arb_latency", waited, 0);
    w_phase(0, 4, 4, -1);
    b_phase(0, 4'd3, 2'b00, 0, 0, 1'b0);

    // Backpressure on W and B.
    aw_phase(0, 4'd7, 32'h100, 4'd3, waited);
    w_phase(0, 4, 4, 2);
    b_phase(0, 4'd7, 2'b10, 5, 2, 1'b0);

    // Early wlast on beat 2 of 4.
    aw_phase(1, 4'd2, 32'h200, 4'd3, waited);
    w_phase(1, 2, 2, -1);
    b_phase(1, 4'd2, 2'b00, 0, 0, 1'b1);

    // Count reaches len without wlast.
    aw_phase(0, 4'd4, 32'h300, 4'd1, waited);
    w_phase(0, 2, 0, -1);
    b_phase(0, 4'd4, 2'b00, 0, 0, 1'b1);

    // Contention from reset: m0, then m1 back-to-back, then m0 again.
    do_reset();
    m_awid[1] = 4'd9; m_awaddr[1] = 32'h400; m_awlen[1] = 4'd0; m_awvalid[1] = 1'b1;
    aw_phase(0, 4'd1, 32'h500, 4'd0, waited);
    check("cont_first_wait", waited, 1);
    w_phase(0, 1, 1, -1);
    b_phase(0, 4'd1, 2'b00, 0, 0, 1'b0);
    aw_phase(1, 4'd9, 32'h400, 4'd0, waited);
    check("cont_b2b_wait", waited, 0);
    w_phase(1, 1, 1, -1);
    b_phase(1, 4'd9, 2'b00, 0, 0, 1'b0);
    m_awvalid[1] = 1'b1;
    aw_phase(0, 4'd6, 32'h600, 4'd0, waited);
    check("cont_third_wait", waited, 0);

    // Fixed priority instance with both masters saturating.
    do_reset();
    for (int m = 0; m < 2; m++) begin
      m_awvalid[m] = 1'b1; m_awlen[m] = 4'd0;
      m_wvalid[m] = 1'b1; m_wlast[m] = 1'b1; m_bready[m] = 1'b1;
    end
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
    cnt_g1 = 0; cnt_m1 = 0; cnt_b = 0; cnt_busy = 0; cnt_err = 0;
    for (int i = 0; i < 16; i++) begin
      sample();
      if (f_grant) cnt_g1++;
      if (f_m1_awready || f_m1_wready || f_m1_bvalid) cnt_m1++;
      if (f_m0_bvalid && f_s_bready) cnt_b++;
      if (f_busy) cnt_busy++;
      if (f_err_wlast) cnt_err++;
      tick();
    end
    check("fixed_grant_m1_cycles", cnt_g1, 0);
    check("fixed_m1_handshakes", cnt_m1, 0);
    check("fixed_m0_b_count", cnt_b, 4);
    check("fixed_busy_cycles", cnt_busy, 12);
    check("fixed_err_pulses", cnt_err, 0);

    // Reset after beat 2 of 4, then a clean m1 transaction.
    do_reset();
    aw_phase(0, 4'd5, 32'h700, 4'd3, waited);
    w_phase(0, 2, 0, -1);
    m_wvalid[0] = 1'b1; s_wready = 1'b1; reset = 1'b1;
    sample();
    check("midrst_s_wvalid_during", s_wvalid, 0);
    check("midrst_m0_wready_during", m0_wready, 0);
    tick();
    reset = 1'b0;
    all_idle();
    sample();
    check("midrst_busy", busy, 0);
    check("midrst_grant", grant, 0);
    check("midrst_s_wvalid", s_wvalid, 0);
    check("midrst_s_awvalid", s_awvalid, 0);
    check("midrst_s_bready", s_bready, 0);
    aw_phase(1, 4'd5, 32'h40, 4'd1, waited);
    w_phase(1, 2, 2, -1);
    b_phase(1, 4'd5, 2'b00, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
